// File: rtl/icon_pkg.sv
// Shared constants, stage-1 record type and the icon ROM contents
// for the player-sprite renderer.
package icon_pkg;

    localparam logic [1:0] ORIENT_N = 2'd0;
    localparam logic [1:0] ORIENT_E = 2'd1;
    localparam logic [1:0] ORIENT_S = 2'd2;
    localparam logic [1:0] ORIENT_W = 2'd3;

    localparam logic [1:0] ICON_TRANSPARENT = 2'b00;
    localparam int         ICON_ADDR_W      = 9;
    localparam int         H_ACTIVE         = 640;
    localparam int         V_ACTIVE         = 480;

    typedef struct packed {
        logic       hit;
        logic       phase;
        logic [3:0] row;
        logic [3:0] col;
    } stage1_t;

    // Phase 0: checkerboard of codes 1/2 with a single code-3 marker at
    // (row 0, col 15). Phase 1: transparent diagonal, 1 below it, 2 above it.
    function automatic logic [1:0] icon_rom_word(input logic [ICON_ADDR_W-1:0] addr);
        logic [3:0] row;
        logic [3:0] col;
        logic [1:0] word;
        row = addr[7:4];
        col = addr[3:0];
        if (addr[8] == 1'b0) begin
            if (row == 4'd0 && col == 4'd15) begin
                word = 2'b11;
            end else if ((row[0] ^ col[0]) == 1'b1) begin
                word = 2'b01;
            end else begin
                word = 2'b10;
            end
        end else begin
            if (row == col) begin
                word = ICON_TRANSPARENT;
            end else if (row > col) begin
                word = 2'b01;
            end else begin
                word = 2'b10;
            end
        end
        return word;
    endfunction

endpackage

// File: rtl/icon_renderer_if.sv
// Scan-position / sprite-placement bus between the display timing side
// (master) and the icon renderer (slave).
interface icon_renderer_if;
    logic       vert_sync;
    logic [9:0] pixel_row;
    logic [9:0] pixel_column;
    logic [8:0] LocX_reg;
    logic [8:0] LocY_reg;
    logic [1:0] orient;
    logic [1:0] icon_pixel;
    logic       frame_tick;

    modport master (
        output vert_sync, pixel_row, pixel_column, LocX_reg, LocY_reg, orient,
        input  icon_pixel, frame_tick
    );

    modport slave (
        input  vert_sync, pixel_row, pixel_column, LocX_reg, LocY_reg, orient,
        output icon_pixel, frame_tick
    );
endinterface

// File: rtl/icon_rom.sv
// 512x2 synchronous icon ROM (two 16x16 animation phases), registered read.
module icon_rom
    import icon_pkg::*;
(
    input  logic                   clk,
    input  logic [ICON_ADDR_W-1:0] addr,
    output logic [1:0]             data
);

    // Registered read port; contents are a fixed function of the address.
    always_ff @(posedge clk) begin
        data <= icon_rom_word(addr);
    end

endmodule

// File: rtl/icon_renderer.sv
// Player-sprite pixel source: per-frame position latch, animation phase,
// hit test with orientation transform, and a fixed 3-cycle pixel pipeline.
module icon_renderer
    import icon_pkg::*;
#(
    parameter int         ICON_SIZE     = 16,
    parameter logic [5:0] ANIM_DIV      = 6'd15,
    parameter bit         VS_ACTIVE_LOW = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    icon_renderer_if.slave bus
);

    localparam logic       VS_IDLE  = VS_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [3:0] EDGE_MAX = 4'(ICON_SIZE - 1);

    logic       vs_q_r;
    logic       sync_start_s;
    logic [8:0] lx_r;
    logic [8:0] ly_r;
    logic [1:0] lo_r;
    logic [5:0] anim_cnt_r;
    logic       phase_r;
    logic       frame_tick_r;

    logic [10:0] dx_s;
    logic [10:0] dy_s;
    logic        hit_s;
    logic [3:0]  u_s;
    logic [3:0]  v_s;
    logic [3:0]  rom_row_s;
    logic [3:0]  rom_col_s;

    stage1_t                s1_r;
    logic                   hit_d_r;
    logic [ICON_ADDR_W-1:0] rom_addr_s;
    logic [1:0]             rom_q_s;
    logic [1:0]             icon_pixel_r;

    assign sync_start_s = (bus.vert_sync != VS_IDLE) && (vs_q_r == VS_IDLE);

    // Frame latch, frame tick and animation counter, all keyed to sync start.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            vs_q_r       <= VS_IDLE;
            frame_tick_r <= 1'b0;
            lx_r         <= 9'd0;
            ly_r         <= 9'd0;
            lo_r         <= ORIENT_N;
            anim_cnt_r   <= 6'd0;
            phase_r      <= 1'b0;
        end else begin
            vs_q_r       <= bus.vert_sync;
            frame_tick_r <= sync_start_s;
            if (sync_start_s) begin
                lx_r <= bus.LocX_reg;
                ly_r <= bus.LocY_reg;
                lo_r <= bus.orient;
                if (anim_cnt_r == ANIM_DIV) begin
                    anim_cnt_r <= 6'd0;
                    phase_r    <= ~phase_r;
                end else begin
                    anim_cnt_r <= anim_cnt_r + 6'd1;
                end
            end
        end
    end

    // Negative offsets wrap to >= 1024 as unsigned, so one compare covers both bounds.
    assign dx_s  = {1'b0, bus.pixel_column} - {2'b00, lx_r};
    assign dy_s  = {1'b0, bus.pixel_row}    - {2'b00, ly_r};
    assign hit_s = (dx_s < 11'(ICON_SIZE)) && (dy_s < 11'(ICON_SIZE));
    assign u_s   = dx_s[3:0];
    assign v_s   = dy_s[3:0];

    // Map screen-local (u, v) to ROM (col, row) for the latched heading.
    always_comb begin
        rom_col_s = u_s;
        rom_row_s = v_s;
        case (lo_r)
            ORIENT_N: begin rom_col_s = u_s;            rom_row_s = v_s;            end
            ORIENT_E: begin rom_col_s = v_s;            rom_row_s = EDGE_MAX - u_s; end
            ORIENT_S: begin rom_col_s = EDGE_MAX - u_s; rom_row_s = EDGE_MAX - v_s; end
            ORIENT_W: begin rom_col_s = EDGE_MAX - v_s; rom_row_s = u_s;            end
            default:  begin rom_col_s = u_s;            rom_row_s = v_s;            end
        endcase
    end

    assign rom_addr_s = {s1_r.phase, s1_r.row, s1_r.col};

    icon_rom u_rom (
        .clk  (sys_clk),
        .addr (rom_addr_s),
        .data (rom_q_s)
    );

    // Pixel pipeline: stage-1 record, hit delayed alongside the ROM read, output.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            s1_r         <= '0;
            hit_d_r      <= 1'b0;
            icon_pixel_r <= ICON_TRANSPARENT;
        end else begin
            s1_r.hit     <= hit_s;
            s1_r.phase   <= phase_r;
            s1_r.row     <= rom_row_s;
            s1_r.col     <= rom_col_s;
            hit_d_r      <= s1_r.hit;
            icon_pixel_r <= hit_d_r ? rom_q_s : ICON_TRANSPARENT;
        end
    end

    assign bus.icon_pixel = icon_pixel_r;
    assign bus.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_icon_renderer.sv
// Scoreboard bench for icon_renderer: randomized and directed scans checked
// against a coordinate-level reference model of the sprite.
module tb_icon_renderer;
    import icon_pkg::*;

    localparam int DIV = 2;
    localparam int SZ  = 16;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    always #5 sys_clk = ~sys_clk;

    icon_renderer_if bus();

    icon_renderer #(
        .ICON_SIZE     (SZ),
        .ANIM_DIV      (6'(DIV)),
        .VS_ACTIVE_LOW (1'b1)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    typedef struct {
        int         due;
        logic [1:0] pix;
    } exp_t;

    exp_t pix_q[$];
    int   tick_q[$];
    exp_t e_m;
    exp_t e_s;
    logic exp_tick_m;

    int edge_cnt = 0;
    int total    = 0;
    int bad      = 0;
    int rom_m[512];

    int   frames;
    logic prev_vs;
    int   m_lx, m_ly, m_lo;
    int   cur_x, cur_y, cur_o;

    always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

    // Expected sprite code at a screen position from the latched model state.
    function automatic int model_pix(input int row, input int col);
        int dx, dy, u, v, t, ph;
        dx = col - m_lx;
        dy = row - m_ly;
        if (dx < 0 || dx >= SZ || dy < 0 || dy >= SZ) return 0;
        u = dx;
        v = dy;
        for (int k = 0; k < m_lo; k++) begin
            t = u;
            u = v;
            v = SZ - 1 - t;
        end
        ph = (frames / (DIV + 1)) % 2;
        return rom_m[ph * 256 + v * 16 + u];
    endfunction

    // Monitor: compares frame_tick every cycle and each pixel at its due cycle.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            pix_q.delete();
            tick_q.delete();
        end else begin
            exp_tick_m = 1'b0;
            if (tick_q.size() > 0 && tick_q[0] <= edge_cnt) begin
                exp_tick_m = 1'b1;
                void'(tick_q.pop_front());
            end
            total++;
            if (bus.frame_tick !== exp_tick_m) begin
                bad++;
                $display("FAIL frame_tick cyc=%0d got=%b exp=%b", edge_cnt, bus.frame_tick, exp_tick_m);
            end
            while (pix_q.size() > 0 && pix_q[0].due <= edge_cnt) begin
                e_m = pix_q.pop_front();
                total++;
                if (bus.icon_pixel !== e_m.pix || e_m.due != edge_cnt) begin
                    bad++;
                    $display("FAIL icon_pixel cyc=%0d due=%0d got=%b exp=%b", edge_cnt, e_m.due, bus.icon_pixel, e_m.pix);
                end
            end
        end
    end

    task automatic step(input logic vs, input int row, input int col);
        @(negedge sys_clk);
        bus.vert_sync    = vs;
        bus.pixel_row    = 10'(row);
        bus.pixel_column = 10'(col);
        bus.LocX_reg     = 9'(cur_x);
        bus.LocY_reg     = 9'(cur_y);
        bus.orient       = 2'(cur_o);
        e_s.due = edge_cnt + 3;
        e_s.pix = 2'(model_pix(row, col));
        pix_q.push_back(e_s);
        if (vs == 1'b0 && prev_vs == 1'b1) begin
            tick_q.push_back(edge_cnt + 1);
            m_lx = cur_x;
            m_ly = cur_y;
            m_lo = cur_o;
            frames++;
        end
        prev_vs = vs;
    endtask

    task automatic frame();
        step(1'b1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        repeat (3) step(1'b0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        step(1'b1, 0, 1023);
    endtask

    task automatic scan(input int r0, input int c0, input int h, input int w);
        for (int r = r0; r < r0 + h; r++)
            for (int c = c0; c < c0 + w; c++)
                step(1'b1, r & 1023, c & 1023);
    endtask

    task automatic model_reset();
        frames  = 0;
        m_lx    = 0;
        m_ly    = 0;
        m_lo    = 0;
        prev_vs = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (bus.icon_pixel !== 2'b00) begin
            bad++;
            $display("FAIL %s_pixel got=%b exp=00", tag, bus.icon_pixel);
        end
        total++;
        if (bus.frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL %s_tick got=%b exp=0", tag, bus.frame_tick);
        end
    endtask

    initial begin
        int row, col;
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++) begin
                    if (p == 0) rom_m[p*256 + r*16 + c] = (r == 0 && c == 15) ? 3 : (((r + c) % 2 == 1) ? 1 : 2);
                    else        rom_m[p*256 + r*16 + c] = (r == c) ? 0 : ((r > c) ? 1 : 2);
                end
        bus.vert_sync = 1'b1; bus.pixel_row = 10'd0; bus.pixel_column = 10'd0;
        bus.LocX_reg = 9'd0; bus.LocY_reg = 9'd0; bus.orient = 2'd0;
        cur_x = 0; cur_y = 0; cur_o = 0;
        model_reset();
        repeat (3) @(negedge sys_clk);
        #1 check_reset_outputs("por");
        #1 sys_rst = 1'b1;

        // Before any latch the icon sits at (0,0), N, phase 0.
        cur_x = 200; cur_y = 200;
        scan(0, 0, 18, 18);

        // Placement at (100,50) facing N, including columns 99 and 116.
        cur_x = 100; cur_y = 50; cur_o = 0;
        frame();
        scan(48, 98, 20, 20);

        // Mid-frame move is ignored until the next sync start.
        cur_x = 300;
        scan(50, 96, 4, 24);
        frame();
        scan(50, 96, 4, 24);
        scan(49, 298, 18, 20);

        // Each heading over the full icon.
        for (int o = 1; o < 4; o++) begin
            cur_o = o;
            frame();
            scan(50, 300, 16, 16);
        end

        // Animation phases over several consecutive frames.
        cur_o = 0;
        for (int f = 0; f < 7; f++) begin
            frame();
            scan(50, 300, 2, 16);
        end

        // Far right placement: no wrap back to low columns.
        cur_x = 511; cur_y = 400;
        frame();
        scan(400, 505, 3, 26);
        scan(400, 0, 3, 16);
        scan(400, 1016, 3, 8);

        // Random placements, headings and scan positions.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                cur_x = int'($urandom_range(0, 511));
                cur_y = int'($urandom_range(0, 479));
                cur_o = int'($urandom_range(0, 3));
                frame();
            end
            if ($urandom_range(0, 99) < 3) cur_x = int'($urandom_range(0, 511));
            if ($urandom_range(0, 9) == 0) begin
                row = int'($urandom_range(0, 1023));
                col = int'($urandom_range(0, 1023));
            end else begin
                row = m_ly - 2 + int'($urandom_range(0, 19));
                col = m_lx - 2 + int'($urandom_range(0, 19));
                if (row < 0) row = 0;
                if (col < 0) col = 0;
            end
            step(1'b1, row, col);
        end

        // Asynchronous reset in the middle of a line over the icon.
        cur_x = 40; cur_y = 30; cur_o = 2;
        frame();
        scan(30, 40, 1, 10);
        #3 sys_rst = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        repeat (2) @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        scan(0, 0, 3, 18);
        frame();
        scan(30, 40, 16, 16);

        repeat (5) step(1'b1, 1000, 1000);
        repeat (4) @(negedge sys_clk);
        #1;
        total++;
        if (pix_q.size() != 0 || tick_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending_pix=%0d pending_tick=%0d exp=0", pix_q.size(), tick_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        bad++;
        $display("FAIL watchdog time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
